// File: rtl/d_cache_ctrl_pkg.sv
// Shared constants, field widths and FSM encoding for the write-through data cache.
package d_cache_ctrl_pkg;

    localparam int unsigned LATENCY_DEF = 4;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned TAG_W       = 12;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned OFF_W       = 2;
    localparam int unsigned NUM_LINES   = 1 << IDX_W;
    localparam int unsigned LINE_WORDS  = 1 << OFF_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRmiss = 2'd1,
        StWrite = 2'd2
    } state_t;

endpackage

// File: rtl/d_cache_array.sv
// Valid/tag/data storage: combinational read port, one synchronous write port
// (full-line fill or single-word update).
module d_cache_array
    import d_cache_ctrl_pkg::*;
#(
    parameter int unsigned WORD = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [IDX_W-1:0]           i_rd_idx,
    output logic                       o_rd_valid,
    output logic [TAG_W-1:0]           o_rd_tag,
    output logic [LINE_WORDS*WORD-1:0] o_rd_line,
    input  logic                       i_fill,
    input  logic                       i_upd,
    input  logic [IDX_W-1:0]           i_wr_idx,
    input  logic [OFF_W-1:0]           i_wr_off,
    input  logic [TAG_W-1:0]           i_wr_tag,
    input  logic [LINE_WORDS*WORD-1:0] i_wr_line,
    input  logic [WORD-1:0]            i_wr_word
);

    logic [NUM_LINES-1:0]       r_valid;
    logic [TAG_W-1:0]           r_tag  [NUM_LINES];
    logic [LINE_WORDS*WORD-1:0] r_data [NUM_LINES];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge i_clk) begin
        if (i_fill) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_line;
        end else if (i_upd) begin
            r_data[i_wr_idx][WORD*i_wr_off +: WORD] <= i_wr_word;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-through data cache controller: zero-stall read hits,
// 4-word line fill on read miss, write-through with no allocate.
module d_cache_ctrl
    import d_cache_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned WORD    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_d_read,
    input  logic                       i_d_write,
    input  logic [ADDR_W-1:0]          i_d_addr,
    input  logic [WORD-1:0]            i_d_wdata,
    output logic [WORD-1:0]            o_d_rdata,
    output logic                       o_d_stall,
    output logic                       o_mem_read,
    output logic                       o_mem_write,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [WORD-1:0]            o_mem_wdata,
    input  logic [LINE_WORDS*WORD-1:0] i_mem_rdata,
    output logic [15:0]                o_rd_hits,
    output logic [15:0]                o_rd_misses
);

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD-1:0]     r_wdata;
    logic                r_hit;
    logic [15:0]         r_rd_hits;
    logic [15:0]         r_rd_misses;

    logic                       w_valid;
    logic [TAG_W-1:0]           w_tag;
    logic [LINE_WORDS*WORD-1:0] w_line;
    logic                       w_hit;
    logic                       w_last;
    logic                       w_accept;
    logic                       w_fill;
    logic                       w_upd;

    d_cache_array #(
        .WORD (WORD)
    ) u_array (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (i_d_addr[OFF_W +: IDX_W]),
        .o_rd_valid (w_valid),
        .o_rd_tag   (w_tag),
        .o_rd_line  (w_line),
        .i_fill     (w_fill),
        .i_upd      (w_upd),
        .i_wr_idx   (r_addr[OFF_W +: IDX_W]),
        .i_wr_off   (r_addr[OFF_W-1:0]),
        .i_wr_tag   (r_addr[ADDR_W-1 -: TAG_W]),
        .i_wr_line  (i_mem_rdata),
        .i_wr_word  (r_wdata)
    );

    assign w_hit    = w_valid && (w_tag == i_d_addr[ADDR_W-1 -: TAG_W]);
    assign w_last   = (r_cnt == CNT_LAST);
    assign w_accept = (r_state == StIdle) && (i_d_write || (i_d_read && !w_hit));
    assign w_fill   = (r_state == StRmiss) && w_last;
    assign w_upd    = (r_state == StWrite) && w_last && r_hit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_d_write) begin
                    w_state_next = StWrite;
                end else if (i_d_read && !w_hit) begin
                    w_state_next = StRmiss;
                end
            end
            StRmiss, StWrite: begin
                if (w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_d_rdata   = '0;
        o_d_stall   = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        // Reset forces every handshake low even mid-access.
        if (!i_reset) begin
            unique case (r_state)
                StIdle: begin
                    if (i_d_write) begin
                        o_d_stall   = 1'b1;
                        o_mem_write = 1'b1;
                        o_mem_addr  = i_d_addr;
                        o_mem_wdata = i_d_wdata;
                    end else if (i_d_read) begin
                        if (w_hit) begin
                            o_d_rdata = w_line[WORD*i_d_addr[OFF_W-1:0] +: WORD];
                        end else begin
                            o_d_stall  = 1'b1;
                            o_mem_read = 1'b1;
                            o_mem_addr = {i_d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                StRmiss: begin
                    o_mem_read = 1'b1;
                    o_mem_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    o_d_stall  = !w_last;
                    if (w_last) begin
                        o_d_rdata = i_mem_rdata[WORD*r_addr[OFF_W-1:0] +: WORD];
                    end
                end
                StWrite: begin
                    o_mem_write = 1'b1;
                    o_mem_addr  = r_addr;
                    o_mem_wdata = r_wdata;
                    o_d_stall   = !w_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hit   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= 4'd1;
            r_addr  <= i_d_addr;
            r_wdata <= i_d_wdata;
            r_hit   <= w_hit;
        end else if (r_state != StIdle) begin
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_hits   <= '0;
            r_rd_misses <= '0;
        end else if ((r_state == StIdle) && i_d_read && !i_d_write) begin
            if (w_hit) begin
                r_rd_hits <= r_rd_hits + 16'd1;
            end else begin
                r_rd_misses <= r_rd_misses + 16'd1;
            end
        end
    end

    assign o_rd_hits   = r_rd_hits;
    assign o_rd_misses = r_rd_misses;

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl with a fixed-latency memory model that only
// presents valid line data in the LATENCY-th cycle of a held read.
module tb_d_cache_ctrl;

    localparam int unsigned LAT  = 4;
    localparam int unsigned WORD = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_read;
    logic              d_write;
    logic [15:0]       d_addr;
    logic [WORD-1:0]   d_wdata;
    logic [WORD-1:0]   d_rdata;
    logic              d_stall;
    logic              mem_read;
    logic              mem_write;
    logic [15:0]       mem_addr;
    logic [WORD-1:0]   mem_wdata;
    logic [4*WORD-1:0] mem_rdata;
    logic [15:0]       rd_hits;
    logic [15:0]       rd_misses;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:1023];
    int          rd_cyc;

    always #5 clk = ~clk;

    d_cache_ctrl #(
        .LATENCY (LAT),
        .WORD    (WORD)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_d_read    (d_read),
        .i_d_write   (d_write),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_rdata   (d_rdata),
        .o_d_stall   (d_stall),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_rd_hits   (rd_hits),
        .o_rd_misses (rd_misses)
    );

    // Cycle number within the current held mem_read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cyc <= 0;
        end else if (mem_read && rd_cyc != LAT - 1) begin
            rd_cyc <= rd_cyc + 1;
        end else begin
            rd_cyc <= 0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (mem_read && rd_cyc == LAT - 1) begin
                mem_rdata[WORD*i +: WORD] = mem[{mem_addr[9:2], 2'(i)}];
            end else begin
                mem_rdata[WORD*i +: WORD] = 16'hDEAD;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue a load and follow it to completion; inputs change at posedge+1, outputs
    // are sampled at the negedge.
    task automatic do_read(input string tag, input logic [15:0] a, input logic exp_hit,
                           input logic [15:0] exp_data);
        int          stalls = 0;
        int          mrd    = 0;
        logic        done   = 1'b0;
        logic        bad_a  = 1'b0;
        logic [15:0] got    = '0;
        @(posedge clk); #1;
        d_read = 1'b1;
        d_addr = a;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (mem_read) begin
                mrd++;
                if (mem_addr !== {a[15:2], 2'b00}) bad_a = 1'b1;
            end
            if (!d_stall) begin
                done = 1'b1;
                got  = d_rdata;
            end else begin
                stalls++;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stalls"}, stalls, exp_hit ? 0 : LAT - 1);
        check({tag, "_memrd_cycles"}, mrd, exp_hit ? 0 : LAT);
        check({tag, "_memaddr_bad"}, 32'(bad_a), 32'd0);
        check({tag, "_rdata"}, 32'(got), 32'(exp_data));
        @(posedge clk); #1;
        d_read = 1'b0;
    endtask

    // Issue a store (optionally with d_read also high) and follow it to completion;
    // the memory model commits what the DUT presents in the final cycle.
    task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] wd,
                            input logic also_read);
        int          stalls = 0;
        int          mwr    = 0;
        logic        done   = 1'b0;
        logic        bad    = 1'b0;
        @(posedge clk); #1;
        d_write = 1'b1;
        d_read  = also_read;
        d_addr  = a;
        d_wdata = wd;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (mem_write) begin
                mwr++;
                if (mem_addr !== a || mem_wdata !== wd) bad = 1'b1;
            end
            if (mem_read) bad = 1'b1;
            if (!d_stall) begin
                done = 1'b1;
                if (mem_write) mem[mem_addr[9:0]] = mem_wdata;
            end else begin
                stalls++;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stalls"}, stalls, LAT - 1);
        check({tag, "_memwr_cycles"}, mwr, LAT);
        check({tag, "_addr_data_bad"}, 32'(bad), 32'd0);
        @(posedge clk); #1;
        d_write = 1'b0;
        d_read  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(16'h1000 + i);
        reset   = 1'b1;
        d_read  = 1'b1;
        d_write = 1'b0;
        d_addr  = 16'h0012;
        d_wdata = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(d_stall), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'(d_rdata), 32'd0);
        check("rst_hits", 32'(rd_hits), 32'd0);
        check("rst_misses", 32'(rd_misses), 32'd0);
        d_read = 1'b0;
        reset  = 1'b0;

        do_read("cold_0012", 16'h0012, 1'b0, 16'h1012);
        check("cold_misses", 32'(rd_misses), 32'd1);
        do_read("hit_0013", 16'h0013, 1'b1, 16'h1013);
        check("hit_hits", 32'(rd_hits), 32'd1);

        do_write("wr_hit_0011", 16'h0011, 16'hBEEF, 1'b0);
        check("wr_hit_mem", 32'(mem[16'h0011]), 32'hBEEF);
        do_read("rd_0011", 16'h0011, 1'b1, 16'hBEEF);
        check("rd_0011_hits", 32'(rd_hits), 32'd2);

        // Write miss must not allocate; 0x0040 shares index 0 with 0x0012.
        do_write("wr_miss_0040", 16'h0040, 16'h1234, 1'b0);
        check("wr_miss_mem", 32'(mem[16'h0040]), 32'h1234);
        do_read("rd_0040", 16'h0040, 1'b0, 16'h1234);
        check("rd_0040_misses", 32'(rd_misses), 32'd2);

        do_read("rd_0012_again", 16'h0012, 1'b0, 16'h1012);
        do_read("rd_0112", 16'h0112, 1'b0, 16'h1112);
        do_read("rd_0012_repl", 16'h0012, 1'b0, 16'h1012);
        check("repl_misses", 32'(rd_misses), 32'd5);
        do_read("rd_0011_refill", 16'h0011, 1'b1, 16'hBEEF);
        check("refill_hits", 32'(rd_hits), 32'd3);

        // Write has priority over a simultaneous read and is not a load.
        do_write("wr_prio_0014", 16'h0014, 16'h5555, 1'b1);
        check("prio_misses", 32'(rd_misses), 32'd5);
        check("prio_hits", 32'(rd_hits), 32'd3);
        check("prio_mem", 32'(mem[16'h0014]), 32'h5555);

        // Reset at cnt=2 of a miss.
        @(posedge clk); #1;
        d_read = 1'b1;
        d_addr = 16'h0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pre_stall", 32'(d_stall), 32'd1);
        reset  = 1'b1;
        d_read = 1'b0;
        #1;
        check("mid_stall", 32'(d_stall), 32'd0);
        check("mid_mem_read", 32'(mem_read), 32'd0);
        check("mid_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_hits", 32'(rd_hits), 32'd0);
        check("mid_misses", 32'(rd_misses), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_read("post_rst_0013", 16'h0013, 1'b0, 16'h1013);
        do_read("post_rst_0020", 16'h0020, 1'b0, 16'h1020);
        check("post_rst_misses", 32'(rd_misses), 32'd2);
        check("post_rst_hits", 32'(rd_hits), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
